// File: rtl/fnd_msg_scroller_if.sv
// rtl/fnd_msg_scroller_if.sv - mode inputs and FND/frame outputs of the message scroller
interface fnd_msg_scroller_if #(
    parameter int NUM_DIGITS = 3
);
    logic                    morning_signal;
    logic                    after_signal;
    logic [7*NUM_DIGITS-1:0] fnd;
    logic                    frame_done;

    modport master (
        output morning_signal,
        output after_signal,
        input  fnd,
        input  frame_done
    );

    modport slave (
        input  morning_signal,
        input  after_signal,
        output fnd,
        output frame_done
    );
endinterface

// File: rtl/fnd_msg_scroller.sv
// rtl/fnd_msg_scroller.sv - scrolling "A-P"/"P-A" FND message engine; FND_BLINK_EN blinks the held message
module fnd_msg_scroller #(
    parameter int NUM_DIGITS = 3,
    parameter int SCROLL_DIV = 25_000_000,
    parameter int HOLD_STEPS = 4
) (
    input  logic                clk,
    input  logic                rst,
    fnd_msg_scroller_if.slave   bus
);
    localparam int L  = 3 + NUM_DIGITS;
    localparam int OW = $clog2(L);
    localparam int PW = $clog2(SCROLL_DIV);
    localparam int HW = $clog2(HOLD_STEPS + 1);

    localparam logic [6:0] GLYPH_A     = 7'b000_1000;
    localparam logic [6:0] GLYPH_P     = 7'b000_1100;
    localparam logic [6:0] GLYPH_DASH  = 7'b011_1111;
    localparam logic [6:0] GLYPH_BLANK = 7'h7f;

    typedef enum logic [1:0] {MODE_NONE, MODE_MORN, MODE_AFT} mode_e;
    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SCROLL} state_e;

    mode_e                   mode_q, mode_d, mode_dec;
    state_e                  state_q, state_d;
    logic [OW-1:0]           offset_q, offset_d;
    logic [HW-1:0]           h_q, h_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic                    wrap_q, wrap_d;
    logic                    frame_done_q;
    logic [7*NUM_DIGITS-1:0] fnd_q, fnd_d;
    logic                    tick;

    function automatic logic [6:0] glyph(input mode_e m, input int j);
        logic [6:0] g;
        g = GLYPH_BLANK;
        if (j == 1) begin
            g = GLYPH_DASH;
        end else if (j == 0) begin
            g = (m == MODE_MORN) ? GLYPH_A : GLYPH_P;
        end else if (j == 2) begin
            g = (m == MODE_MORN) ? GLYPH_P : GLYPH_A;
        end
        return g;
    endfunction

    always_comb begin
        mode_dec = MODE_NONE;
        if (bus.morning_signal) begin
            mode_dec = MODE_MORN;
        end else if (bus.after_signal) begin
            mode_dec = MODE_AFT;
        end
    end

    assign tick = (state_q != S_IDLE) && (presc_q == PW'(SCROLL_DIV - 1));

    always_comb begin
        mode_d   = mode_dec;
        state_d  = state_q;
        offset_d = offset_q;
        h_d      = h_q;
        presc_d  = presc_q;
        wrap_d   = 1'b0;
        // A mode change restarts the message and suppresses any tick in the same cycle
        if (mode_dec != mode_q) begin
            offset_d = '0;
            h_d      = '0;
            presc_d  = '0;
            state_d  = (mode_dec == MODE_NONE) ? S_IDLE : S_HOLD;
        end else begin
            case (state_q)
                S_HOLD: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        if (h_q == HW'(HOLD_STEPS - 1)) begin
                            state_d  = S_SCROLL;
                            offset_d = OW'(1);
                            h_d      = '0;
                        end else begin
                            h_d = h_q + HW'(1);
                        end
                    end
                end
                S_SCROLL: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        if (offset_q == OW'(L - 1)) begin
                            state_d  = S_HOLD;
                            offset_d = '0;
                            wrap_d   = 1'b1;
                        end else begin
                            offset_d = offset_q + OW'(1);
                        end
                    end
                end
                default: begin
                    presc_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        fnd_d = '1;
        if (state_q != S_IDLE) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                fnd_d[7*i +: 7] = glyph(mode_q, (int'(offset_q) + i) % L);
            end
        end
`ifdef FND_BLINK_EN
        if (state_q == S_HOLD && h_q[0]) begin
            fnd_d = '1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= MODE_NONE;
            state_q      <= S_IDLE;
            offset_q     <= '0;
            h_q          <= '0;
            presc_q      <= '0;
            wrap_q       <= 1'b0;
            frame_done_q <= 1'b0;
            fnd_q        <= '1;
        end else begin
            mode_q       <= mode_d;
            state_q      <= state_d;
            offset_q     <= offset_d;
            h_q          <= h_d;
            presc_q      <= presc_d;
            wrap_q       <= wrap_d;
            frame_done_q <= wrap_q;
            fnd_q        <= fnd_d;
        end
    end

    assign bus.fnd        = fnd_q;
    assign bus.frame_done = frame_done_q;
endmodule
